// File: rtl/mul_div_sequencer_if.sv
// Execute-stage handshake between the pipeline and the RV32M multiply/divide sequencer.
interface mul_div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] operandA;
    logic [XLEN-1:0] operandB;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, operandA, operandB, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, func3, operandA, operandB, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one bit per cycle, stalls the pipeline while running.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module mul_div_sequencer #(
    parameter int XLEN = 32
) (
    input logic                clk,
    input logic                rstN,
    mul_div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    // state | meaning
    // IDLE  | waiting for start; special cases resolve straight to DONE
    // RUN   | one multiplier/quotient bit per cycle, counter 0..31
    // DONE  | result valid for one cycle, pipeline released
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      func3_q, func3_d;
    logic            neg_q, neg_d;
    logic            sgn_a_q, sgn_a_d;
    logic [XLEN-1:0] op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_div, signed_a, signed_b, a_neg, b_neg;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    always_comb begin
        is_div      = bus.func3[2];
        signed_a    = is_div ? !bus.func3[0] : (bus.func3[1:0] != 2'b11);
        signed_b    = is_div ? !bus.func3[0] : !bus.func3[1];
        a_neg       = signed_a & bus.operandA[XLEN-1];
        b_neg       = signed_b & bus.operandB[XLEN-1];
        mag_a       = a_neg ? -bus.operandA : bus.operandA;
        mag_b       = b_neg ? -bus.operandB : bus.operandB;
        div_by_zero = is_div && (bus.operandB == '0);
        div_ovf     = is_div && !bus.func3[0]
                      && (bus.operandA == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.operandB == '1);
        if (div_by_zero)
            spec_res = bus.func3[1] ? bus.operandA : '1;
        else
            spec_res = bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     fast_a, fast_b;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    // 33x33 signed multiply; only the low 64 bits of the product are ever needed.
    always_comb begin
        fast_a    = {signed_a & bus.operandA[XLEN-1], bus.operandA};
        fast_b    = {signed_b & bus.operandB[XLEN-1], bus.operandB};
        fast_prod = {{(XLEN-1){fast_a[XLEN]}}, fast_a} * {{(XLEN-1){fast_b[XLEN]}}, fast_b};
        fast_res  = (bus.func3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Multiply: hi accumulates, lo shifts the multiplier out and the product low half in.
    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, quo_c, rem_c, fin_res;
    logic [2*XLEN-1:0] prod_c;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, op_q};
        if (func3_q[2]) begin
            step_hi = div_ge ? (div_shift[XLEN-1:0] - op_q) : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_c = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_c  = neg_q ? -step_lo : step_lo;
        rem_c  = sgn_a_q ? -step_hi : step_hi;
        if (func3_q[2])
            fin_res = func3_q[1] ? rem_c : quo_c;
        else
            fin_res = (func3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    func3_d = bus.func3;
                    cnt_d   = '0;
                    hi_d    = '0;
                    neg_d   = a_neg ^ b_neg;
                    sgn_a_d = a_neg;
                    op_d    = is_div ? mag_b : mag_a;
                    lo_d    = is_div ? mag_a : mag_b;
                    if (div_by_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = spec_res;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = fin_res;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // Combinational stall holds the issuing cycle; DONE releases the pipeline.
    assign bus.stall  = ((state_q == IDLE) && bus.start && !bus.flush) || (state_q == RUN);
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomized self-checking bench for mul_div_sequencer against an arithmetic reference model.
module tb_mul_div_sequencer;
    logic clk = 1'b0;
    logic rstN;

    mul_div_sequencer_if #(.XLEN(32)) bus ();
    mul_div_sequencer #(.XLEN(32)) dut (.clk(clk), .rstN(rstN), .bus(bus));

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit pend = 1'b0;
    int issue_cyc = 0;
    int exp_lat = 0;
    logic [31:0] exp_res = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int sai, sbi;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        sai = a;
        sbi = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sai / sbi);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sai % sbi);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!f[2]) return MUL_LAT;
        return 33;
    endfunction

    // Per-cycle comparison of the handshake outputs against the pending-op timeline.
    always @(negedge clk) begin
        if (chk_en && rstN) begin
            int rel;
            logic e_stall, e_busy, e_done;
            rel = 0;
            e_stall = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (pend) begin
                rel = cyc - issue_cyc;
                e_stall = (rel < exp_lat);
                e_busy = (rel >= 1);
                e_done = (rel == exp_lat);
            end
            chk("stall", {31'b0, bus.stall}, {31'b0, e_stall});
            chk("busy", {31'b0, bus.busy}, {31'b0, e_busy});
            chk("done", {31'b0, bus.done}, {31'b0, e_done});
            if (e_done) begin
                chk("result", bus.result, exp_res);
                pend = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_stall"}, {31'b0, bus.stall}, 32'h0);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
        chk({tag, "_done"}, {31'b0, bus.done}, 32'h0);
        chk({tag, "_result"}, bus.result, 32'h0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after the op ends.
    task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                         int kill_rel, bit dup_start, bit use_reset);
        int len;
        len = lat_of(f, a, b);
        bus.start = 1'b1;
        bus.func3 = f;
        bus.operandA = a;
        bus.operandB = b;
        pend = 1'b1;
        issue_cyc = cyc;
        exp_lat = len;
        exp_res = model(f, a, b);
        tick();
        bus.start = 1'b0;
        bus.func3 = 3'($urandom);
        bus.operandA = $urandom;
        bus.operandB = $urandom;
        if (kill_rel > 0 && kill_rel < len) begin
            while (cyc < issue_cyc + kill_rel) tick();
            if (use_reset) begin
                rstN = 1'b0;
                #1;
                pend = 1'b0;
                chk_reset_outputs("async_reset");
                tick();
                tick();
                rstN = 1'b1;
                tick();
            end else begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                pend = 1'b0;
            end
        end else begin
            while (cyc < issue_cyc + len) tick();
            if (dup_start) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
    endtask

    task automatic planned(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                           logic [31:0] lit_res, int lit_lat);
        chk("model_pin_result", model(f, a, b), lit_res);
        chk("model_pin_latency", 32'(lat_of(f, a, b)), 32'(lit_lat));
        issue(f, a, b, 0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rstN = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.func3 = 3'd0;
        bus.operandA = '0;
        bus.operandB = '0;
        #2;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        chk_en = 1'b1;
        tick();

        planned(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        planned(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        planned(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        planned(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        planned(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        planned(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        planned(3'd5, 32'd100, 32'd7, 32'd14, 33);
        planned(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        planned(3'd7, 32'd5, 32'd0, 32'd5, 1);
        planned(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        planned(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Flush at cycle 10 of a DIV; cycle 11 must be idle, and a MUL issues there.
        issue(3'd4, 32'd1000, 32'd3, 10, 1'b0, 1'b0);
        chk("flush_idle_stall", {31'b0, bus.stall}, 32'h0);
        chk("flush_idle_busy", {31'b0, bus.busy}, 32'h0);
        issue(3'd0, 32'd12, 32'hFFFF_FFF0, 0, 1'b0, 1'b0);

        // start during DONE belongs to the retiring op
        issue(3'd5, 32'd12345, 32'd17, 0, 1'b1, 1'b0);

        // start together with flush in IDLE is dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.func3 = 3'd5;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (2) tick();

        // Reset at cycle 15 of a DIVU, then idle with no done pulse
        issue(3'd5, 32'hDEAD_BEEF, 32'd13, 15, 1'b0, 1'b1);
        repeat (40) tick();

        for (int n = 0; n < 250; n++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            int kr;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            kr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 40)) : 0;
            issue(f, a, b, kr, ($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

- Execute-stage sequencer for RV32M multiply/divide instructions.
- Accepts one operation from the execute stage and runs it iteratively, one bit per cycle. Stalls the pipeline while the operation runs, then presents the 32-bit result for one cycle.
- Sits beside the single-cycle ALU. The execute stage routes R-type instructions with func7 = 7'b0000001 here instead of to the ALU.

## Interface

Parameters:
- XLEN, 32, operand/result width (only 32 supported)

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  asynchronous active-low reset
- start  input  1  M-extension op valid in execute stage
- func3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operandA  input  32  rs1 value
- operandB  input  32  rs2 value
- flush  input  1  kill in-flight op (branch mispredict/trap)
- stall  output  1  hold IF/ID/EX pipeline registers
- busy  output  1  state != IDLE
- done  output  1  one-cycle result-valid pulse
- result  output  32  registered result, valid while done = 1

One clock; reset is asynchronous and active-low.

## Operation

States: IDLE, RUN, DONE.

- IDLE
  - On start && !flush: latch magnitudes |A| and |B| (signed ops only; MULHSU takes |A| only), latch the result sign, func3, counter = 0.
  - Go to RUN, except for the special cases below, which go straight to DONE with the result preloaded.
- Special cases (divide only):
  - B = 0: quotient = 0xFFFFFFFF; remainder = A.
  - Signed DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- RUN, multiply: shift-add into a 64-bit accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle; 32-bit remainder register, 32-bit quotient register.
- RUN exit: after the cycle with counter = 31, go to DONE; result register is loaded with the sign-corrected output.
- Output selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Sign correction:
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ.
  - Remainder takes the sign of the dividend.
- DONE: done = 1 for exactly one cycle; unconditionally return to IDLE.
  - start seen in DONE belongs to the finishing instruction and is ignored.
- flush in any state: next state IDLE, no done pulse. Flush and start together in IDLE: flush wins.

## Timing

- Reset values: state IDLE, stall 0, busy 0, done 0, result 0, counter 0, internal registers 0.
- stall = (IDLE && start && !flush) || RUN. It is combinational so the issuing cycle is held, and it is 0 in DONE so the instruction retires with result.
- Normal op with start at cycle 0: RUN cycles 1–32, DONE (done = 1) at cycle 33. stall is high for cycles 0–32.
- Special-case op with start at cycle 0: DONE at cycle 1; stall high at cycle 0 only.
- Back-to-back: a new start is accepted at the cycle after DONE (IDLE).
- Reset asserted mid-RUN: all outputs go to reset values immediately; no done pulse after release.
- Counter is 5 bits. RUN terminates on counter = 31 with no wrap.

## Configuration

- MULDIV_FAST_MUL_EN defined:
  - Multiply ops (func3[2] = 0) use a single-cycle combinational 33x33 signed multiplier.
  - Multiply goes IDLE -> DONE; done at cycle 1, stall for cycle 0 only.
  - Divide is unchanged.
- Undefined: multiply uses the 32-cycle iterative path described above. The hardware multiplier is not instantiated.

## Test plan

- MUL, A = 7, B = 0xFFFFFFFD (-3), start at cycle 0 -> done at cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN), result 0xFFFFFFEB; stall high cycles 0–32.
- MULH, A = B = 0x80000000 -> result 0x40000000. MULHU on the same operands -> 0x40000000. MULHSU, A = 0xFFFFFFFF, B = 2 -> 0xFFFFFFFF.
- DIV, A = 0xFFFFFFF9 (-7), B = 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU, A = 100, B = 7 -> 14.
- Division edge cases, all with done at cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- DIV started at cycle 0, flush at cycle 10 -> no done pulse, stall 0 and busy 0 at cycle 11; a new MUL started at cycle 11 completes normally.
- rstN low at cycle 15 of a DIVU -> stall, busy, done and result all 0 asynchronously; after release the block sits in IDLE with no done pulse.
